// File: rtl/tpm_regs_pkg.sv
// Shared register offsets, default read word and IRQ bit positions for the
// TPM <-> SoC communication register window.
package tpm_regs_pkg;

  localparam logic [31:0] OFF_STATUS     = 32'h0000_0000;
  localparam logic [31:0] OFF_OP_TYPE    = 32'h0000_0004;
  localparam logic [31:0] OFF_LOCALITY   = 32'h0000_0008;
  localparam logic [31:0] OFF_BUF_SIZE   = 32'h0000_000C;
  localparam logic [31:0] OFF_IRQ_STATUS = 32'h0000_0010;
  localparam logic [31:0] OFF_IRQ_ENABLE = 32'h0000_0014;
  localparam logic [31:0] OFF_COMPLETE   = 32'h0000_0040;

  localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADF_ABAC;

  localparam int IRQ_BIT_EXEC  = 0;
  localparam int IRQ_BIT_ABORT = 1;

endpackage

// File: rtl/tpm_regs_wb_sync_2ff.sv
// Two-flop synchroniser for the LCLK-domain exec/abort level signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/tpm_regs_wb.sv
// Wishbone slave exposing the regs_module handshake to firmware and driving the complete pulse.
// Optional interrupt logic is built when TPM_REGS_IRQ_EN is defined.
module tpm_regs_wb #(
  parameter int          ADDR_WIDTH           = 11,
  parameter int          BUF_LEN_WIDTH        = 11,
  parameter int          COMPLETE_PULSE_WIDTH = 20,
  parameter logic [31:0] DEFAULT_READ_VALUE   = tpm_regs_pkg::DEFAULT_READ_VALUE
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wb_sel_i,
  input  logic [ADDR_WIDTH-1:0]    wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_be_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  input  logic                     exec_i,
  input  logic                     abort_i,
  input  logic [3:0]               op_type_i,
  input  logic [3:0]               locality_i,
  input  logic [BUF_LEN_WIDTH-1:0] buf_len_i,
  output logic                     complete_o,
  output logic                     irq_o
);
  import tpm_regs_pkg::*;

  logic [1:0]               sync_q;
  logic                     exec_s;
  logic                     abort_s;
  logic                     exec_d;
  logic                     exec_rise;
  logic [3:0]               op_q;
  logic [3:0]               loc_q;
  logic [BUF_LEN_WIDTH-1:0] len_q;
  logic                     req;
  logic                     wr_commit;
  logic [31:0]              offset;
  logic [31:0]              rd_data;
  logic [7:0]               pulse_cnt;
  logic                     unused_bits;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .din    ({abort_i, exec_i}),
    .dout   (sync_q)
  );

  assign exec_s    = sync_q[0];
  assign abort_s   = sync_q[1];
  assign exec_rise = exec_s & ~exec_d;

  // Command attributes are only stable while exec is high, so latch them on its rising edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exec_d <= 1'b0;
      op_q   <= '0;
      loc_q  <= '0;
      len_q  <= '0;
    end else begin
      exec_d <= exec_s;
      if (exec_rise) begin
        op_q  <= op_type_i;
        loc_q <= locality_i;
        len_q <= buf_len_i;
      end
    end
  end

  assign req       = wb_sel_i & wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_commit = req & wb_we_i & wb_be_i[0];
  assign offset    = 32'({wb_adr_i[ADDR_WIDTH-1:2], 2'b00});

  // A COMPLETE write during an active pulse is dropped so the pulse length stays fixed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pulse_cnt <= '0;
    end else if (wr_commit && offset == OFF_COMPLETE && pulse_cnt == '0) begin
      pulse_cnt <= 8'(COMPLETE_PULSE_WIDTH);
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - 8'd1;
    end
  end

  assign complete_o = (pulse_cnt != '0);

`ifdef TPM_REGS_IRQ_EN
  logic       abort_d;
  logic [1:0] irq_status;
  logic [1:0] irq_enable;
  logic [1:0] irq_set;
  logic [1:0] irq_clr;

  always_comb begin
    irq_set                = '0;
    irq_set[IRQ_BIT_EXEC]  = exec_rise;
    irq_set[IRQ_BIT_ABORT] = abort_s & ~abort_d;
    irq_clr                = '0;
    if (wr_commit && offset == OFF_IRQ_STATUS) irq_clr = wb_dat_i[1:0];
  end

  // Set is applied after clear so a fresh edge survives a coincident W1C.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      abort_d    <= 1'b0;
      irq_status <= '0;
      irq_enable <= '0;
    end else begin
      abort_d    <= abort_s;
      irq_status <= (irq_status & ~irq_clr) | irq_set;
      if (wr_commit && offset == OFF_IRQ_ENABLE) irq_enable <= wb_dat_i[1:0];
    end
  end

  assign irq_o = |(irq_status & irq_enable);
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_data = DEFAULT_READ_VALUE;
    case (offset)
      OFF_STATUS:     rd_data = {29'b0, complete_o, abort_s, exec_s};
      OFF_OP_TYPE:    rd_data = 32'(op_q);
      OFF_LOCALITY:   rd_data = 32'(loc_q);
      OFF_BUF_SIZE:   rd_data = 32'(len_q);
`ifdef TPM_REGS_IRQ_EN
      OFF_IRQ_STATUS: rd_data = {30'b0, irq_status};
      OFF_IRQ_ENABLE: rd_data = {30'b0, irq_enable};
`endif
      default:        rd_data = DEFAULT_READ_VALUE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_data : '0;
    end
  end

  assign unused_bits = ^{wb_dat_i, wb_be_i[3:1], wb_adr_i[1:0]};

endmodule

// File: tb/tb_tpm_regs_wb.sv
// Scoreboard bench for tpm_regs_wb: bus reads/ack patterns queue expectations, compared on ack.
module tb_tpm_regs_wb;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        wb_sel_i = 1'b0;
  logic [10:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_be_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        exec_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  op_type_i = '0;
  logic [3:0]  locality_i = '0;
  logic [10:0] buf_len_i = '0;
  logic        complete_o;
  logic        irq_o;

  localparam logic [10:0] A_STATUS = 11'h000;
  localparam logic [10:0] A_OP     = 11'h004;
  localparam logic [10:0] A_LOC    = 11'h008;
  localparam logic [10:0] A_LEN    = 11'h00C;
  localparam logic [10:0] A_IRQST  = 11'h010;
  localparam logic [10:0] A_IRQEN  = 11'h014;
  localparam logic [10:0] A_CMPL   = 11'h040;
  localparam logic [31:0] DEF_VAL  = 32'hBADFABAC;

  int          total_cnt = 0;
  int          bad_cnt = 0;
  logic [31:0] exp_q[$];

  tpm_regs_wb dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wb_sel_i   (wb_sel_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_we_i    (wb_we_i),
    .wb_be_i    (wb_be_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .exec_i     (exec_i),
    .abort_i    (abort_i),
    .op_type_i  (op_type_i),
    .locality_i (locality_i),
    .buf_len_i  (buf_len_i),
    .complete_o (complete_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic act, input logic cyc, input logic we,
                               input logic [10:0] adr, input logic [31:0] dat, input logic [3:0] be);
    wb_sel_i = act;
    wb_stb_i = act;
    wb_cyc_i = cyc;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_be_i  = be;
  endtask

  // Called at a falling edge; finishes one idle cycle after the ack.
  task automatic bus_access(input string tag, input logic we, input logic [10:0] adr,
                            input logic [31:0] dat, input logic [3:0] be, input logic [31:0] want);
    int lat;
    logic [31:0] exp_v;
    applyStimulus(1'b1, 1'b1, we, adr, dat, be);
    exp_q.push_back(want);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!wb_ack_o && lat < 4);
    exp_v = exp_q.pop_front();
    if (wb_ack_o) begin
      checkOutput({tag, "_ack_lat"}, 32'(lat), 32'd1);
      if (!we) checkOutput(tag, wb_dat_o, exp_v);
    end else begin
      checkOutput({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);
  endtask

  task automatic wb_read(input string tag, input logic [10:0] adr, input logic [31:0] want);
    bus_access(tag, 1'b0, adr, '0, 4'hF, want);
  endtask

  task automatic wb_write(input string tag, input logic [10:0] adr, input logic [31:0] dat,
                          input logic [3:0] be);
    bus_access(tag, 1'b1, adr, dat, be, '0);
  endtask

  task automatic count_complete(input int cycles, output int high);
    high = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      if (complete_o) high++;
    end
  endtask

  initial begin
    logic       cyc_pat [8];
    logic       model_ack;
    int         high_cnt;

    #3;
    checkOutput("rst_ack", 32'(wb_ack_o), 32'd0);
    checkOutput("rst_dat", wb_dat_o, 32'd0);
    checkOutput("rst_complete", 32'(complete_o), 32'd0);
    checkOutput("rst_irq", 32'(irq_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] reset-state register reads");
    wb_read("rd_status0", A_STATUS, 32'h0);
    wb_read("rd_op0", A_OP, 32'h0);
    wb_read("rd_loc0", A_LOC, 32'h0);
    wb_read("rd_len0", A_LEN, 32'h0);
    wb_read("rd_cmpl", A_CMPL, DEF_VAL);
    wb_read("rd_unmapped", 11'h7FC, DEF_VAL);

    $display("[TB] ack pattern with stb held and cyc toggling");
    cyc_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    model_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, cyc_pat[k], 1'b0, A_STATUS, '0, 4'hF);
      model_ack = cyc_pat[k] & ~model_ack;
      exp_q.push_back(32'(model_ack));
      @(negedge clk_i);
      checkOutput($sformatf("ack_pat%0d", k), 32'(wb_ack_o), exp_q.pop_front());
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);

    $display("[TB] exec handshake and held command attributes");
    op_type_i  = 4'd2;
    locality_i = 4'd3;
    buf_len_i  = 11'h040;
    exec_i     = 1'b1;
    wb_read("status_early", A_STATUS, 32'h0);
    wb_read("status_exec", A_STATUS, 32'h1);
    op_type_i  = 4'd7;
    locality_i = 4'd1;
    buf_len_i  = 11'h123;
    wb_read("rd_op", A_OP, 32'd2);
    wb_read("rd_loc", A_LOC, 32'd3);
    wb_read("rd_len", A_LEN, 32'h40);

    abort_i = 1'b1;
    repeat (3) @(negedge clk_i);
    wb_read("status_abort", A_STATUS, 32'h3);

`ifdef TPM_REGS_IRQ_EN
    $display("[TB] interrupt status and enable");
    checkOutput("irq_masked", 32'(irq_o), 32'd0);
    wb_read("irqst_both", A_IRQST, 32'h3);
    wb_write("irqen_wr", A_IRQEN, 32'h1, 4'hF);
    checkOutput("irq_on", 32'(irq_o), 32'd1);
    wb_read("irqen_rd", A_IRQEN, 32'h1);
    wb_write("irqen_be0", A_IRQEN, 32'h3, 4'hE);
    wb_read("irqen_rd_be0", A_IRQEN, 32'h1);
    wb_write("w1c_exec", A_IRQST, 32'h1, 4'hF);
    checkOutput("irq_off", 32'(irq_o), 32'd0);
    wb_read("irqst_abort", A_IRQST, 32'h2);
    exec_i = 1'b0;
    repeat (4) @(negedge clk_i);
    exec_i = 1'b1;
    repeat (2) @(negedge clk_i);
    wb_write("w1c_race", A_IRQST, 32'h1, 4'hF);
    wb_read("irqst_race", A_IRQST, 32'h3);
    checkOutput("irq_race", 32'(irq_o), 32'd1);
    wb_write("w1c_all", A_IRQST, 32'h3, 4'hF);
    wb_read("irqst_clr", A_IRQST, 32'h0);
`else
    $display("[TB] interrupt logic absent");
    wb_read("irqst_def", A_IRQST, DEF_VAL);
    wb_read("irqen_def", A_IRQEN, DEF_VAL);
    checkOutput("irq_tied", 32'(irq_o), 32'd0);
`endif

    $display("[TB] complete pulse width and ignored re-trigger");
    high_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 0 || c == 10) applyStimulus(1'b1, 1'b1, 1'b1, A_CMPL, 32'h1, 4'hF);
      @(negedge clk_i);
      if (c == 0 || c == 10) begin
        checkOutput($sformatf("cmpl_ack%0d", c), 32'(wb_ack_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (complete_o) high_cnt++;
    end
    checkOutput("cmpl_width", 32'(high_cnt), 32'd20);

    wb_write("cmpl_be0", A_CMPL, 32'h1, 4'hE);
    count_complete(25, high_cnt);
    checkOutput("cmpl_be0_width", 32'(high_cnt), 32'd0);

    $display("[TB] reset during an active pulse");
    applyStimulus(1'b1, 1'b1, 1'b1, A_CMPL, 32'h1, 4'hF);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("pre_rst_complete", 32'(complete_o), 32'd1);
    repeat (6) @(negedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("async_rst_complete", 32'(complete_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    count_complete(30, high_cnt);
    checkOutput("no_resume", 32'(high_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
